cv32e41s_ram_obi_dp: RTL and testbench

Single-clock, true dual-port word-addressed memory with two independent OBI-style request/response ports, byte-enable writes, configurable read latency and address-range error reporting. Instruction and data interfaces of the cv32e41s core attach to it directly in the SoC memory subsystem. It replaces raw enable/write-enable RAM ports with a req/gnt/rvalid handshake and defines collision arbitration between the two ports.

---
 rtl/cv32e41s_ram_obi_dp_pkg.sv | 36 +++
 rtl/cv32e41s_ram_obi_dp_if.sv | 33 +++
 rtl/cv32e41s_ram_obi_dp_resp_pipe.sv | 61 ++++++
 rtl/cv32e41s_ram_obi_dp.sv | 138 +++++++++++++
 tb/tb_cv32e41s_ram_obi_dp.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e41s_ram_obi_dp_pkg.sv
// Shared types and helpers for the dual-port OBI RAM: byte-offset width,
// response status record and the port collision rule.
package cv32e41s_ram_pkg;

  // Number of low address bits that select a byte inside one word.
  function automatic int unsigned byte_off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Byte-offset width for the default 32-bit word.
  localparam int unsigned BYTE_OFF_W = byte_off_width(32);

  // Response status carried down the per-port delay line. The data word
  // is parameter-sized per instance, so it travels next to this record
  // rather than inside it.
  typedef struct packed {
    logic valid;
    logic err;
  } resp_status_t;

  // Two requests collide when both target the same in-range word and at
  // least one of them writes. Two reads of one word never collide.
  function automatic logic is_collision(
    input logic        a_req,
    input logic        a_we,
    input logic        a_hit,
    input logic [63:0] a_idx,
    input logic        b_req,
    input logic        b_we,
    input logic        b_hit,
    input logic [63:0] b_idx
  );
    return a_req && b_req && a_hit && b_hit && (a_idx == b_idx) && (a_we || b_we);
  endfunction

endpackage

// File: rtl/cv32e41s_ram_obi_dp_if.sv
// One OBI-style request/response port: the master drives the request
// side, the slave answers with gnt and the response. The resp modport is
// the response-only view used by the per-port response pipeline.
interface cv32e41s_ram_obi_dp_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

  modport resp (
    output rvalid, rdata, err
  );

endinterface

// File: rtl/cv32e41s_ram_obi_dp_resp_pipe.sv
// Per-port response pipeline: turns a grant into rvalid/err after the
// configured read latency, zeroes rdata on errors and idle cycles, and
// adds an output register stage when READ_LATENCY is 2.
module cv32e41s_ram_resp_pipe
  import cv32e41s_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  grant,      // request accepted this cycle
  input  logic                  oor,        // accepted request is out of range
  input  logic [DATA_WIDTH-1:0] mem_rdata,  // array read register
  cv32e41s_ram_obi_dp_if.resp   bus
);

  resp_status_t          stage1_q;
  logic [DATA_WIDTH-1:0] stage1_data;

  // First stage: remember whether a response is due and whether it errs.
  // NOTE: state uses <= so every flop samples the pre-edge values; a
  // blocking assignment here would let later reads see the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
    end else begin
      stage1_q.valid <= grant;
      stage1_q.err   <= grant & oor;
    end
  end

  // The array register is not reset, so data is only passed on for a
  // valid, in-range response; everything else reads as zero.
  assign stage1_data = (stage1_q.valid && !stage1_q.err) ? mem_rdata : '0;

  if (READ_LATENCY == 2) begin : g_out_reg
    resp_status_t          out_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    // Output stage: one extra register on rvalid/err/rdata.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q      <= '0;
        out_data_q <= '0;
      end else begin
        out_q      <= stage1_q;
        out_data_q <= stage1_data;
      end
    end

    assign bus.rvalid = out_q.valid;
    assign bus.err    = out_q.err;
    assign bus.rdata  = out_data_q;
  end else begin : g_direct
    assign bus.rvalid = stage1_q.valid;
    assign bus.err    = stage1_q.err;
    assign bus.rdata  = stage1_data;
  end

endmodule

// File: rtl/cv32e41s_ram_obi_dp.sv
// True dual-port word-addressed RAM with two OBI-style ports, byte-enable
// writes, read-first behaviour, port-A priority on collisions and
// out-of-range error responses.
module cv32e41s_ram_obi_dp
  import cv32e41s_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  output logic                    a_err_o,

  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic                    b_rvalid_o,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    b_err_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = byte_off_width(DATA_WIDTH);
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Bundle each flat port into an interface instance.
  cv32e41s_ram_obi_dp_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) a_bus ();
  cv32e41s_ram_obi_dp_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) b_bus ();

  assign a_bus.req   = a_req_i;
  assign a_bus.addr  = a_addr_i;
  assign a_bus.we    = a_we_i;
  assign a_bus.be    = a_be_i;
  assign a_bus.wdata = a_wdata_i;
  assign a_gnt_o     = a_bus.gnt;
  assign a_rvalid_o  = a_bus.rvalid;
  assign a_rdata_o   = a_bus.rdata;
  assign a_err_o     = a_bus.err;

  assign b_bus.req   = b_req_i;
  assign b_bus.addr  = b_addr_i;
  assign b_bus.we    = b_we_i;
  assign b_bus.be    = b_be_i;
  assign b_bus.wdata = b_wdata_i;
  assign b_gnt_o     = b_bus.gnt;
  assign b_rvalid_o  = b_bus.rvalid;
  assign b_rdata_o   = b_bus.rdata;
  assign b_err_o     = b_bus.err;

  // Address decode: word index, range check and array address.
  logic [ADDR_WIDTH-1:0] a_idx, b_idx;
  logic                  a_hit, b_hit;
  logic [IDX_W-1:0]      a_word, b_word;

  assign a_idx  = a_bus.addr >> OFF_W;
  assign b_idx  = b_bus.addr >> OFF_W;
  assign a_hit  = (64'(a_idx) < 64'(MEM_DEPTH));
  assign b_hit  = (64'(b_idx) < 64'(MEM_DEPTH));
  assign a_word = a_idx[IDX_W-1:0];
  assign b_word = b_idx[IDX_W-1:0];

  // Grant: A always wins; B waits while it collides with A.
  logic collision;
  logic a_gnt, b_gnt;

  assign collision = is_collision(a_bus.req, a_bus.we, a_hit, 64'(a_idx),
                                  b_bus.req, b_bus.we, b_hit, 64'(b_idx));
  assign a_gnt     = a_bus.req;
  assign b_gnt     = b_bus.req & ~collision;
  assign a_bus.gnt = a_gnt;
  assign b_bus.gnt = b_gnt;

  // Array access enables: every in-range grant reads (read-first data for
  // writes too); out-of-range grants touch nothing.
  logic a_rd_en, b_rd_en;
  logic a_wr_en, b_wr_en;

  assign a_rd_en = a_gnt & a_hit;
  assign b_rd_en = b_gnt & b_hit;
  assign a_wr_en = a_rd_en & a_bus.we;
  assign b_wr_en = b_rd_en & b_bus.we;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] a_mem_rdata, b_mem_rdata;

  // Memory array with per-lane write enables and registered read data.
  // NOTE: the array and its read registers are deliberately not reset so
  // the tools map them onto block RAM; the response pipe masks the data
  // until a valid response exists.
  always_ff @(posedge clk_i) begin
    if (a_rd_en) a_mem_rdata <= mem[a_word];
    if (b_rd_en) b_mem_rdata <= mem[b_word];
    for (int i = 0; i < BE_W; i++) begin
      if (a_wr_en && a_bus.be[i]) mem[a_word][8*i +: 8] <= a_bus.wdata[8*i +: 8];
      if (b_wr_en && b_bus.be[i]) mem[b_word][8*i +: 8] <= b_bus.wdata[8*i +: 8];
    end
  end

  cv32e41s_ram_resp_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_a_resp (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .grant     (a_gnt),
    .oor       (~a_hit),
    .mem_rdata (a_mem_rdata),
    .bus       (a_bus.resp)
  );

  cv32e41s_ram_resp_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_b_resp (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .grant     (b_gnt),
    .oor       (~b_hit),
    .mem_rdata (b_mem_rdata),
    .bus       (b_bus.resp)
  );

endmodule

// File: tb/tb_cv32e41s_ram_obi_dp.sv
// Self-checking bench: a vector table drives both ports of a latency-1
// instance; a hand-written sequence covers latency 2 and mid-run reset.
module tb_cv32e41s_ram_obi_dp;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cv32e41s_ram_obi_dp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a_if (), b_if (), c_if (), d_if ();

  cv32e41s_ram_obi_dp #(.READ_LATENCY(1)) dut_l1 (
    .clk_i      (clk),        .rst_ni     (rst_n),
    .a_req_i    (a_if.req),   .a_gnt_o    (a_if.gnt),
    .a_addr_i   (a_if.addr),  .a_we_i     (a_if.we),
    .a_be_i     (a_if.be),    .a_wdata_i  (a_if.wdata),
    .a_rvalid_o (a_if.rvalid),.a_rdata_o  (a_if.rdata), .a_err_o (a_if.err),
    .b_req_i    (b_if.req),   .b_gnt_o    (b_if.gnt),
    .b_addr_i   (b_if.addr),  .b_we_i     (b_if.we),
    .b_be_i     (b_if.be),    .b_wdata_i  (b_if.wdata),
    .b_rvalid_o (b_if.rvalid),.b_rdata_o  (b_if.rdata), .b_err_o (b_if.err)
  );

  cv32e41s_ram_obi_dp #(.READ_LATENCY(2)) dut_l2 (
    .clk_i      (clk),        .rst_ni     (rst_n),
    .a_req_i    (c_if.req),   .a_gnt_o    (c_if.gnt),
    .a_addr_i   (c_if.addr),  .a_we_i     (c_if.we),
    .a_be_i     (c_if.be),    .a_wdata_i  (c_if.wdata),
    .a_rvalid_o (c_if.rvalid),.a_rdata_o  (c_if.rdata), .a_err_o (c_if.err),
    .b_req_i    (d_if.req),   .b_gnt_o    (d_if.gnt),
    .b_addr_i   (d_if.addr),  .b_we_i     (d_if.we),
    .b_be_i     (d_if.be),    .b_wdata_i  (d_if.wdata),
    .b_rvalid_o (d_if.rvalid),.b_rdata_o  (d_if.rdata), .b_err_o (d_if.err)
  );

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } op_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic        chk;    // compare rdata
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    op_t  a;
    op_t  b;
    exp_t ea;
    exp_t eb;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic op_t rd(input logic [31:0] addr);
    return '{1'b1, 1'b0, addr, 4'h0, 32'h0};
  endfunction

  function automatic op_t wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    return '{1'b1, 1'b1, addr, be, data};
  endfunction

  function automatic op_t nop();
    return '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0};
  endfunction

  function automatic exp_t ok(input logic [31:0] data);   // granted, data checked
    return '{1'b1, 1'b1, 1'b0, 1'b1, data};
  endfunction

  function automatic exp_t acc();                         // granted, old data unknown
    return '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
  endfunction

  function automatic exp_t oor();                         // granted, error response
    return '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0};
  endfunction

  function automatic exp_t none();                        // no grant, no response
    return '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_l1(input op_t a, input op_t b);
    a_if.req = a.req; a_if.we = a.we; a_if.addr = a.addr; a_if.be = a.be; a_if.wdata = a.wdata;
    b_if.req = b.req; b_if.we = b.we; b_if.addr = b.addr; b_if.be = b.be; b_if.wdata = b.wdata;
  endtask

  task automatic drive_l2(input op_t a);
    c_if.req = a.req; c_if.we = a.we; c_if.addr = a.addr; c_if.be = a.be; c_if.wdata = a.wdata;
  endtask

  task automatic check_idle(input string name);
    check_bit ({name, " a_rvalid"}, a_if.rvalid, 1'b0);
    check_bit ({name, " a_err"},    a_if.err,    1'b0);
    check_word({name, " a_rdata"},  a_if.rdata,  32'h0);
    check_bit ({name, " b_rvalid"}, b_if.rvalid, 1'b0);
    check_word({name, " b_rdata"},  b_if.rdata,  32'h0);
    check_bit ({name, " c_rvalid"}, c_if.rvalid, 1'b0);
    check_bit ({name, " c_err"},    c_if.err,    1'b0);
    check_word({name, " c_rdata"},  c_if.rdata,  32'h0);
    check_bit ({name, " d_rvalid"}, d_if.rvalid, 1'b0);
  endtask

  initial begin
    vec_t tbl[$];

    drive_l1(nop(), nop());
    drive_l2(nop());
    d_if.req = 1'b0; d_if.we = 1'b0; d_if.addr = '0; d_if.be = '0; d_if.wdata = '0;

    // Reset state
    #1;
    check_idle("reset");
    check_bit("reset a_gnt", a_if.gnt, 1'b0);
    check_bit("reset b_gnt", b_if.gnt, 1'b0);
    n_vec++;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    //             port A op                          port B op                          A exp            B exp
    tbl.push_back('{wr(32'h10, 32'hDEADBEEF, 4'hF),  wr(32'h00, 32'hCAFEF00D, 4'hF),  acc(),           acc()});
    tbl.push_back('{rd(32'h10),                      nop(),                            ok(32'hDEADBEEF), none()});
    tbl.push_back('{wr(32'h10, 32'h000000AA, 4'h1),  nop(),                            ok(32'hDEADBEEF), none()});
    tbl.push_back('{nop(),                           rd(32'h10),                       none(),          ok(32'hDEADBEAA)});
    tbl.push_back('{wr(32'h20, 32'h11111111, 4'hF),  rd(32'h20),                       acc(),           none()});
    tbl.push_back('{nop(),                           rd(32'h20),                       none(),          ok(32'h11111111)});
    tbl.push_back('{wr(32'h20, 32'h22222222, 4'hF),  rd(32'h20),                       ok(32'h11111111), none()});
    tbl.push_back('{nop(),                           rd(32'h20),                       none(),          ok(32'h22222222)});
    tbl.push_back('{wr(32'h30, 32'h12345678, 4'hF),  nop(),                            acc(),           none()});
    tbl.push_back('{rd(32'h30),                      rd(32'h30),                       ok(32'h12345678), ok(32'h12345678)});
    tbl.push_back('{rd(32'h1000),                    rd(32'h10),                       oor(),           ok(32'hDEADBEAA)});
    tbl.push_back('{rd(32'h1000),                    wr(32'h1000, 32'hFFFFFFFF, 4'hF), oor(),           oor()});
    tbl.push_back('{rd(32'h00),                      rd(32'h02),                       ok(32'hCAFEF00D), ok(32'hCAFEF00D)});
    tbl.push_back('{wr(32'h10, 32'h00000000, 4'h0),  nop(),                            ok(32'hDEADBEAA), none()});
    tbl.push_back('{wr(32'h10, 32'h55667788, 4'h6),  nop(),                            ok(32'hDEADBEAA), none()});
    tbl.push_back('{nop(),                           rd(32'h13),                       none(),          ok(32'hDE6677AA)});
    tbl.push_back('{nop(),                           nop(),                            none(),          none()});
    tbl.push_back('{rd(32'h20),                      wr(32'h20, 32'h33333333, 4'hF),  ok(32'h22222222), none()});
    tbl.push_back('{rd(32'h20),                      wr(32'h20, 32'h33333333, 4'hF),  ok(32'h22222222), none()});
    tbl.push_back('{nop(),                           wr(32'h20, 32'h33333333, 4'hF),  none(),          ok(32'h22222222)});
    tbl.push_back('{rd(32'h20),                      nop(),                            ok(32'h33333333), none()});

    foreach (tbl[i]) begin
      drive_l1(tbl[i].a, tbl[i].b);
      #1;
      check_bit($sformatf("v%0d a_gnt", i), a_if.gnt, tbl[i].ea.gnt);
      check_bit($sformatf("v%0d b_gnt", i), b_if.gnt, tbl[i].eb.gnt);
      @(posedge clk); #1;
      check_bit($sformatf("v%0d a_rvalid", i), a_if.rvalid, tbl[i].ea.rvalid);
      check_bit($sformatf("v%0d a_err", i),    a_if.err,    tbl[i].ea.err);
      if (tbl[i].ea.chk) check_word($sformatf("v%0d a_rdata", i), a_if.rdata, tbl[i].ea.rdata);
      check_bit($sformatf("v%0d b_rvalid", i), b_if.rvalid, tbl[i].eb.rvalid);
      check_bit($sformatf("v%0d b_err", i),    b_if.err,    tbl[i].eb.err);
      if (tbl[i].eb.chk) check_word($sformatf("v%0d b_rdata", i), b_if.rdata, tbl[i].eb.rdata);
      n_vec++;
    end
    drive_l1(nop(), nop());

    // Latency 2: back-to-back writes, responses two cycles after grant
    for (int k = 0; k < 4; k++) begin
      drive_l2(wr(32'(4 * k), 32'hA0A00000 + 32'(k), 4'hF));
      @(posedge clk); #1;
      check_bit($sformatf("l2 wr%0d rvalid", k), c_if.rvalid, (k >= 1));
      n_vec++;
    end
    drive_l2(nop());
    @(posedge clk); #1;
    check_bit("l2 wr3 rvalid", c_if.rvalid, 1'b1);
    @(posedge clk); #1;
    check_bit("l2 drained rvalid", c_if.rvalid, 1'b0);
    n_vec++;

    // Latency 2: back-to-back reads, reset after the second response
    for (int k = 0; k < 3; k++) begin
      drive_l2(rd(32'(4 * k)));
      @(posedge clk); #1;
      check_bit($sformatf("l2 rd%0d rvalid", k), c_if.rvalid, (k >= 1));
      if (k >= 1) begin
        check_word($sformatf("l2 rd%0d rdata", k - 1), c_if.rdata, 32'hA0A00000 + 32'(k - 1));
        check_bit($sformatf("l2 rd%0d err", k - 1), c_if.err, 1'b0);
      end
      n_vec++;
    end
    drive_l2(rd(32'hC));
    rst_n = 1'b0;
    #1;
    check_idle("mid-reset");
    n_vec++;
    @(posedge clk); #1;
    drive_l2(nop());
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_bit($sformatf("post-reset c%0d rvalid", k), c_if.rvalid, 1'b0);
      check_bit($sformatf("post-reset a%0d rvalid", k), a_if.rvalid, 1'b0);
      n_vec++;
    end

    // Memory survives reset: read word 1 on the latency-2 instance
    drive_l2(rd(32'h4));
    @(posedge clk); #1;
    drive_l2(nop());
    @(posedge clk); #1;
    check_bit("l2 after reset rvalid", c_if.rvalid, 1'b1);
    check_word("l2 after reset rdata", c_if.rdata, 32'hA0A00001);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
